fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the 5-stage pipeline's IF/ID register.
- Issues sequential fetch requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned {pc, instr} pairs in a small FIFO and presents them to the pipeline with valid/ready.
- Flushes and restarts at a new PC when a branch is taken in ID.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
start_i  in  1  fetch enable; no new request is issued while low
redirect_i  in  1  taken branch from ID; flush the queue and refetch
redirect_pc_i  in  32  target PC, valid with redirect_i
instr_valid_o  out  1  queue head valid
instr_pc_o  out  32  head PC
instr_o  out  32  head instruction
instr_ready_i  in  1  pipeline consumes the head (low = stall)
mem_req_o  out  1  fetch request
mem_addr_o  out  32  fetch address (word aligned)
mem_ack_i  in  1  one-cycle ack; mem_data_i valid in the same cycle
mem_data_i  in  32  fetched instruction

Behaviour:
- Reset (async assert, sync deassert handled by the system):
  - all outputs 0
  - fetch_pc = RESET_PC
  - FIFO empty, rd/wr pointers 0
  - FSM = IDLE
- FSM states: IDLE, BUSY (request outstanding, data kept), DISCARD (request outstanding, data dropped).
- space = (count + pending_pushes) < DEPTH, evaluated on registered count. At most one request is outstanding.
- IDLE:
  - if start_i and space and no redirect_i → BUSY next cycle; mem_req_o=1 and mem_addr_o=fetch_pc are registered.
  - First request appears the cycle after start_i is sampled high.
- BUSY:
  - mem_req_o and mem_addr_o stay stable until mem_ack_i.
  - On ack: push {mem_addr_o, mem_data_i} and set fetch_pc += 4 (wraps modulo 2^32).
  - If start_i and there is room after the push (count_next < DEPTH) → remain BUSY with the new address next cycle (back-to-back, one fetch per cycle with zero-wait memory). Otherwise → IDLE, mem_req_o=0.
- Requests are never aborted.
  - redirect_i in BUSY without ack → DISCARD; request held until ack.
  - DISCARD + ack → data dropped; → BUSY at the new fetch_pc if start_i, else IDLE.
- redirect_i (any state):
  - FIFO cleared (count=0, pointers reset) and fetch_pc = redirect_pc_i at the next edge.
  - Takes priority over a same-cycle dequeue and a same-cycle push; acked data in that cycle is dropped.
  - redirect_i in DISCARD updates fetch_pc again and stays in DISCARD.
- Output side:
  - instr_valid_o = (count != 0); instr_pc_o and instr_o show the head entry.
  - Pop when instr_valid_o && instr_ready_i && !redirect_i.
  - Simultaneous push and pop: count unchanged, both pointers advance modulo DEPTH.
- Latency: ack in cycle N → entry visible on instr_valid_o in N+1 (FIFO registered, no bypass).
- Full: no request is issued; an outstanding fetch is already reserved a slot by the space rule, so overflow cannot occur.
- Empty: instr_valid_o=0; instr_o/instr_pc_o hold stale data (don't care).
- start_i falling while BUSY: the current request completes and its data is kept; no further requests.
- mem_addr_o[1:0] is always 0; redirect_pc_i[1:0] is ignored (forced 0).
- Asynchronous reset mid-transaction abandons the request. The memory is required to be reset in the same domain, so no late ack is received.

Decomposition:
- Shared package (cpu_pkg):
  - fetch FSM state enum (IDLE/BUSY/DISCARD)
  - XLEN=32, INSTR_BYTES=4
  - fetch entry struct {pc, instr}
- One natural sub-module: sync_fifo (DEPTH, width 64). Push/pop/clear, count output, registered read data at head, clear has priority.

Test Plan:
- Reset, start_i=1, zero-wait memory (ack the cycle after req), instr_ready_i=1 → addresses 0,4,8,12 on consecutive cycles; instr_pc_o follows one cycle after each ack.
- instr_ready_i=0 with 1-cycle ack memory → exactly 4 entries (pc 0..12) held; mem_req_o stays 0 until a pop. One pop → single request to addr 16.
- Memory with 3-cycle latency, redirect_i=1 with redirect_pc_i=0x100 on the cycle after req to 0x8 → req held at 0x8 until ack, data dropped, next req 0x100, first valid entry pc 0x100.
- redirect_i in the same cycle as mem_ack_i and instr_ready_i with count=2 → queue empty next cycle, acked word not enqueued, next mem_addr_o = redirect_pc_i.
- redirect_pc_i=0x103 → mem_addr_o=0x100. fetch_pc=0xFFFF_FFFC followed by an ack → next address 0x0000_0000.
- Assert rst_n_i low mid-BUSY (asynchronous, between edges) → mem_req_o and instr_valid_o drop to 0 immediately; after release, first request goes to RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small register-based FIFO with clear; the head entry is read straight from storage.
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    // Pointers are exactly AW bits wide, so natural overflow wraps modulo DEPTH.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)
                    r_mem[gi] <= '0;
                else if (i_push && !i_clear && (r_wr_ptr == AW'(gi)))
                    r_mem[gi] <= i_wdata;
            end
        end
    endgenerate

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Sequential instruction fetcher: one outstanding memory request, results buffered for the IF/ID stage.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] instr_o,
    input  logic            instr_ready_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_data_i
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_mem_req;
    logic [XLEN-1:0] r_mem_addr;

    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_next;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_resume_pc;
    logic            w_can_issue;
    fetch_entry_t    w_head;
    fetch_entry_t    w_wdata;

    assign w_redirect_pc = word_align(redirect_pc_i);
    assign w_pc_inc      = r_fetch_pc + XLEN'(INSTR_BYTES);
    assign w_resume_pc   = redirect_i ? w_redirect_pc : r_fetch_pc;

    // A redirect wins over everything: acked data that cycle is dropped and no pop happens.
    assign w_push       = (r_state == ST_BUSY) && mem_ack_i && !redirect_i;
    assign w_pop        = instr_valid_o && instr_ready_i && !redirect_i;
    assign w_count_next = redirect_i ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    assign w_can_issue  = start_i && (w_count_next < DEPTH_C);

    assign w_wdata = '{pc: r_mem_addr, instr: mem_data_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= word_align(RESET_PC);
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (redirect_i) begin
                        r_fetch_pc <= w_redirect_pc;
                    end else if (start_i && (w_count < DEPTH_C)) begin
                        r_state    <= ST_BUSY;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                ST_BUSY: begin
                    if (redirect_i) begin
                        r_fetch_pc <= w_redirect_pc;
                        if (!mem_ack_i) begin
                            r_state <= ST_DISCARD;
                        end else if (start_i) begin
                            r_mem_addr <= w_redirect_pc;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end else if (mem_ack_i) begin
                        r_fetch_pc <= w_pc_inc;
                        if (w_can_issue) begin
                            r_mem_addr <= w_pc_inc;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                ST_DISCARD: begin
                    r_fetch_pc <= w_resume_pc;
                    if (mem_ack_i) begin
                        if (w_can_issue) begin
                            r_state    <= ST_BUSY;
                            r_mem_addr <= w_resume_pc;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect_i),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign instr_valid_o = (w_count != '0);
    assign instr_pc_o    = w_head.pc;
    assign instr_o       = w_head.instr;
    assign mem_req_o     = r_mem_req;
    assign mem_addr_o    = r_mem_addr;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; the memory model returns addr + 0x1000_0000 as the instruction.
module tb_fetch_queue;

    localparam logic [31:0] OFF = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ready = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    logic        auto_en = 1'b0;
    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;
    int          lat = 0;
    int          wcnt = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (valid),
        .instr_pc_o    (pc),
        .instr_o       (instr),
        .instr_ready_i (ready),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_data_i    (mem_data)
    );

    assign mem_ack  = auto_ack | man_ack;
    assign mem_data = mem_addr + OFF;

    // Variable-latency memory: ack after 'lat' extra cycles of a held request.
    always @(negedge clk) begin
        if (!rst_n || !auto_en || !mem_req) begin
            auto_ack = 1'b0;
            wcnt     = 0;
        end else if (wcnt >= lat) begin
            auto_ack = 1'b1;
            wcnt     = 0;
        end else begin
            auto_ack = 1'b0;
            wcnt     = wcnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0h want 0", mem_req); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0h want 0", valid); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %0h want 0", pc); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %0h want 0", instr); end
        rst_n = 1'b1;
        tick;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_no_start: got %0h want 0", mem_req); end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back;
        auto_en = 1'b1; lat = 0; ready = 1'b1; start = 1'b1;
        tick;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL b2b_req0: got %0h want 1", mem_req); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL b2b_addr0: got %0h want 0", mem_addr); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_valid0: got %0h want 0", valid); end
        for (int k = 1; k <= 3; k++) begin
            tick;
            total++; if (mem_addr !== 32'(k * 4)) begin bad++; $display("FAIL b2b_addr%0d: got %0h want %0h", k, mem_addr, k * 4); end
            total++; if (valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d: got %0h want 1", k, valid); end
            total++; if (pc !== 32'((k - 1) * 4)) begin bad++; $display("FAIL b2b_pc%0d: got %0h want %0h", k, pc, (k - 1) * 4); end
            total++; if (instr !== 32'((k - 1) * 4) + OFF) begin bad++; $display("FAIL b2b_instr%0d: got %0h want %0h", k, instr, 32'((k - 1) * 4) + OFF); end
        end
        start = 1'b0;
        tick;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL b2b_stop_req: got %0h want 0", mem_req); end
        total++; if (pc !== 32'hC) begin bad++; $display("FAIL b2b_last_pc: got %0h want c", pc); end
        tick;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_drained: got %0h want 0", valid); end
        $display("test_back_to_back done");
    endtask

    task automatic test_full;
        ready = 1'b0; start = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
        tick;
        redirect = 1'b0; start = 1'b1;
        repeat (5) tick;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_req: got %0h want 0", mem_req); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL full_head: got %0h want 0", pc); end
        repeat (3) tick;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_hold_req: got %0h want 0", mem_req); end
        ready = 1'b1;
        tick;
        ready = 1'b0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_pop_req: got %0h want 0", mem_req); end
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL full_pop_head: got %0h want 4", pc); end
        tick;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL full_refill_req: got %0h want 1", mem_req); end
        total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL full_refill_addr: got %0h want 10", mem_addr); end
        start = 1'b0;
        tick;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_refill_done: got %0h want 0", mem_req); end
        $display("test_full done");
    endtask

    task automatic test_redirect_discard;
        ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h8;
        tick;
        redirect = 1'b0; lat = 3; start = 1'b1;
        tick;
        total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL disc_addr: got %0h want 8", mem_addr); end
        redirect = 1'b1; redirect_pc = 32'h100;
        tick;
        redirect = 1'b0;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL disc_hold_req: got %0h want 1", mem_req); end
        total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL disc_hold_addr: got %0h want 8", mem_addr); end
        repeat (2) tick;
        total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL disc_hold_addr2: got %0h want 8", mem_addr); end
        tick;
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL disc_new_addr: got %0h want 100", mem_addr); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL disc_dropped: got %0h want 0", valid); end
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (valid === 1'b1) break;
        end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL disc_timeout: got %0h want 1", valid); end
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL disc_first_pc: got %0h want 100", pc); end
        total++; if (instr !== 32'h1000_0100) begin bad++; $display("FAIL disc_first_instr: got %0h want 10000100", instr); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL disc_stop_req: got %0h want 0", mem_req); end
        $display("test_redirect_discard done");
    endtask

    task automatic test_redirect_same_cycle;
        auto_en = 1'b0; ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
        tick;
        redirect = 1'b0; start = 1'b1;
        tick;
        man_ack = 1'b1;
        repeat (2) tick;
        total++; if (pc !== 32'h40) begin bad++; $display("FAIL same_head: got %0h want 40", pc); end
        total++; if (mem_addr !== 32'h48) begin bad++; $display("FAIL same_addr: got %0h want 48", mem_addr); end
        ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        tick;
        redirect = 1'b0; man_ack = 1'b0; start = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL same_flush: got %0h want 0", valid); end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL same_req: got %0h want 1", mem_req); end
        total++; if (mem_addr !== 32'h200) begin bad++; $display("FAIL same_newaddr: got %0h want 200", mem_addr); end
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        total++; if (pc !== 32'h200) begin bad++; $display("FAIL same_refetch_pc: got %0h want 200", pc); end
        total++; if (instr !== 32'h1000_0200) begin bad++; $display("FAIL same_refetch_instr: got %0h want 10000200", instr); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL same_idle: got %0h want 0", mem_req); end
        $display("test_redirect_same_cycle done");
    endtask

    task automatic test_align_wrap;
        ready = 1'b0; start = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
        tick;
        redirect = 1'b0; start = 1'b1;
        tick;
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL align_addr: got %0h want 100", mem_addr); end
        start = 1'b0; man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL align_pc: got %0h want 100", pc); end
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD;
        tick;
        redirect = 1'b0; start = 1'b1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL wrap_flush: got %0h want 0", valid); end
        tick;
        total++; if (mem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got %0h want fffffffc", mem_addr); end
        man_ack = 1'b1;
        tick;
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next: got %0h want 0", mem_addr); end
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc: got %0h want fffffffc", pc); end
        total++; if (instr !== 32'h0FFF_FFFC) begin bad++; $display("FAIL wrap_instr: got %0h want 0ffffffc", instr); end
        start = 1'b0;
        tick;
        man_ack = 1'b0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL wrap_idle: got %0h want 0", mem_req); end
        $display("test_align_wrap done");
    endtask

    task automatic test_async_reset;
        ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
        tick;
        redirect = 1'b0; auto_en = 1'b1; lat = 0; start = 1'b1;
        repeat (3) tick;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid: got %0h want 1", valid); end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL arst_pre_req: got %0h want 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL arst_req: got %0h want 0", mem_req); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %0h want 0", valid); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL arst_addr: got %0h want 0", mem_addr); end
        tick;
        rst_n = 1'b1;
        tick;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL arst_restart_req: got %0h want 1", mem_req); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL arst_restart_addr: got %0h want 0", mem_addr); end
        start = 1'b0;
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_full;
        test_redirect_discard;
        test_redirect_same_cycle;
        test_align_wrap;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
